if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 126 ++++++++++++
 tb/tb_if_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: walks the PC through a request/ack instruction memory and buffers
// an instruction while the hazard unit holds the pipeline.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        HD_i,
  input  logic        Branch_i,
  input  logic [31:0] BranchAddr_i,
  input  logic        Jump_i,
  input  logic [31:0] JumpAddr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] PC_o,
  output logic [31:0] Instr_o,
  output logic        stall_o,
  output logic        Flush_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] ibuf_r;
  logic [31:0] fetch_cnt_r;
  logic        deliver_s;
  logic        advance_s;

  assign mem_addr_o  = pc_r;
  assign PC_o        = pc_r + 32'd4;
  assign fetch_cnt_o = fetch_cnt_r;

  // Redirect target; jump outranks branch when ID raises both.
  always_comb begin
    pc_next_s = pc_r + 32'd4;
    if (Jump_i) begin
      pc_next_s = JumpAddr_i;
    end else if (Branch_i) begin
      pc_next_s = BranchAddr_i;
    end else begin
      pc_next_s = pc_r + 32'd4;
    end
  end

  // Delivery decode, stage outputs and next state.
  always_comb begin
    deliver_s = 1'b0;
    mem_req_o = 1'b0;
    Instr_o   = 32'h0000_0000;
    state_s   = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        mem_req_o = 1'b1;
        deliver_s = mem_ack_i;
        if (mem_ack_i) begin
          Instr_o = mem_data_i;
          if (HD_i) begin
            state_s = HOLD;
          end else if (start_i) begin
            state_s = FETCH;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        deliver_s = 1'b1;
        Instr_o   = ibuf_r;
        if (HD_i) begin
          state_s = HOLD;
        end else if (start_i) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    advance_s = deliver_s & ~HD_i;
    stall_o   = ~deliver_s;
    Flush_o   = deliver_s & (Branch_i | Jump_i);
  end

  // State, PC, instruction buffer and delivery counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      ibuf_r      <= 32'h0000_0000;
      fetch_cnt_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      if (advance_s) begin
        pc_r        <= pc_next_s;
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      // Capture only on the ack cycle; the memory data is gone afterwards.
      if ((state_r == FETCH) && mem_ack_i && HD_i) begin
        ibuf_r <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a vector table for the main flow plus hand-written
// reset sequences; a second instance with RESET_PC=32'h100 covers the reset-value cases.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, HD_i, Branch_i, Jump_i, mem_ack_i;
  logic [31:0] BranchAddr_i, JumpAddr_i, mem_data_i;

  logic        a_req, a_stall, a_flush;
  logic [31:0] a_addr, a_pc, a_instr, a_cnt;
  logic        b_req, b_stall, b_flush;
  logic [31:0] b_addr, b_pc, b_instr, b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  if_fetch_unit dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .HD_i(HD_i),
    .Branch_i(Branch_i), .BranchAddr_i(BranchAddr_i), .Jump_i(Jump_i), .JumpAddr_i(JumpAddr_i),
    .mem_req_o(a_req), .mem_addr_o(a_addr), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .PC_o(a_pc), .Instr_o(a_instr), .stall_o(a_stall), .Flush_o(a_flush), .fetch_cnt_o(a_cnt)
  );

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .HD_i(HD_i),
    .Branch_i(Branch_i), .BranchAddr_i(BranchAddr_i), .Jump_i(Jump_i), .JumpAddr_i(JumpAddr_i),
    .mem_req_o(b_req), .mem_addr_o(b_addr), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .PC_o(b_pc), .Instr_o(b_instr), .stall_o(b_stall), .Flush_o(b_flush), .fetch_cnt_o(b_cnt)
  );

  typedef struct {
    logic        start, hd, br, jmp, ack;
    logic [31:0] braddr, jaddr, data;
    logic        req;
    logic [31:0] addr, pco, instr;
    logic        stall, flush;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic st, input logic hd, input logic br, input logic [31:0] ba,
                              input logic jp, input logic [31:0] ja, input logic ak, input logic [31:0] dt,
                              input logic rq, input logic [31:0] ad, input logic [31:0] pc,
                              input logic [31:0] ins, input logic sl, input logic fl, input logic [31:0] cn);
    vec_t v;
    v.start = st; v.hd = hd; v.br = br; v.braddr = ba; v.jmp = jp; v.jaddr = ja;
    v.ack = ak; v.data = dt; v.req = rq; v.addr = ad; v.pco = pc; v.instr = ins;
    v.stall = sl; v.flush = fl; v.cnt = cn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic hd, input logic br, input logic [31:0] ba,
                       input logic jp, input logic [31:0] ja, input logic ak, input logic [31:0] dt);
    start_i = st; HD_i = hd; Branch_i = br; BranchAddr_i = ba;
    Jump_i = jp; JumpAddr_i = ja; mem_ack_i = ak; mem_data_i = dt;
  endtask

  task automatic chk_a(input string tag, input logic rq, input logic [31:0] ad, input logic [31:0] pc,
                       input logic [31:0] ins, input logic sl, input logic fl, input logic [31:0] cn);
    chk({tag, ".req"},   {31'd0, a_req},   {31'd0, rq});
    chk({tag, ".addr"},  a_addr,           ad);
    chk({tag, ".pc"},    a_pc,             pc);
    chk({tag, ".instr"}, a_instr,          ins);
    chk({tag, ".stall"}, {31'd0, a_stall}, {31'd0, sl});
    chk({tag, ".flush"}, {31'd0, a_flush}, {31'd0, fl});
    chk({tag, ".cnt"},   a_cnt,            cn);
  endtask

  task automatic chk_b(input string tag, input logic rq, input logic [31:0] ad, input logic [31:0] pc,
                       input logic [31:0] ins, input logic sl, input logic fl, input logic [31:0] cn);
    chk({tag, ".b_req"},   {31'd0, b_req},   {31'd0, rq});
    chk({tag, ".b_addr"},  b_addr,           ad);
    chk({tag, ".b_pc"},    b_pc,             pc);
    chk({tag, ".b_instr"}, b_instr,          ins);
    chk({tag, ".b_stall"}, {31'd0, b_stall}, {31'd0, sl});
    chk({tag, ".b_flush"}, {31'd0, b_flush}, {31'd0, fl});
    chk({tag, ".b_cnt"},   b_cnt,            cn);
  endtask

  initial begin
    // zero-wait stream 0,4,8,12
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,        1'b0,32'h00,32'h04,32'h0,       1'b1,1'b0,32'd0);
    vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hA000_0000,1'b1,32'h00,32'h04,32'hA000_0000,1'b0,1'b0,32'd0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hA000_0001,1'b1,32'h04,32'h08,32'hA000_0001,1'b0,1'b0,32'd1);
    vecs[3]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hA000_0002,1'b1,32'h08,32'h0C,32'hA000_0002,1'b0,1'b0,32'd2);
    vecs[4]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hA000_0003,1'b1,32'h0C,32'h10,32'hA000_0003,1'b0,1'b0,32'd3);
    // 3-cycle latency
    vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'hB000_0000,1'b1,32'h10,32'h14,32'h0,       1'b1,1'b0,32'd4);
    vecs[6]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'hB000_0000,1'b1,32'h10,32'h14,32'h0,       1'b1,1'b0,32'd4);
    vecs[7]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hB000_0000,1'b1,32'h10,32'h14,32'hB000_0000,1'b0,1'b0,32'd4);
    // hazard hold for two cycles, buffered instruction survives changing mem_data_i
    vecs[8]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,32'h8C01_0004,1'b1,32'h14,32'h18,32'h8C01_0004,1'b0,1'b0,32'd5);
    vecs[9]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,32'hDEAD_BEEF,1'b0,32'h14,32'h18,32'h8C01_0004,1'b0,1'b0,32'd5);
    vecs[10] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hDEAD_BEEF,1'b0,32'h14,32'h18,32'h8C01_0004,1'b0,1'b0,32'd5);
    // jump beats branch, then plain branch
    vecs[11] = mk(1'b1,1'b0,1'b1,32'h40,1'b1,32'h80,1'b1,32'hC000_0000,1'b1,32'h18,32'h1C,32'hC000_0000,1'b0,1'b1,32'd6);
    vecs[12] = mk(1'b1,1'b0,1'b1,32'h40,1'b0,32'h0,1'b1,32'hC000_0001,1'b1,32'h80,32'h84,32'hC000_0001,1'b0,1'b1,32'd7);
    // branch while not delivering is ignored; flush with HD, redirect on HOLD advance
    vecs[13] = mk(1'b1,1'b0,1'b1,32'h200,1'b0,32'h0,1'b0,32'hC000_0002,1'b1,32'h40,32'h44,32'h0,     1'b1,1'b0,32'd8);
    vecs[14] = mk(1'b1,1'b1,1'b1,32'h200,1'b0,32'h0,1'b1,32'hC000_0002,1'b1,32'h40,32'h44,32'hC000_0002,1'b0,1'b1,32'd8);
    vecs[15] = mk(1'b1,1'b0,1'b1,32'h300,1'b0,32'h0,1'b0,32'h0,       1'b0,32'h40,32'h44,32'hC000_0002,1'b0,1'b1,32'd8);
    // start_i drop: request completes, then IDLE ignores acks
    vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'hD000_0000,1'b1,32'h300,32'h304,32'h0,    1'b1,1'b0,32'd9);
    vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hD000_0000,1'b1,32'h300,32'h304,32'hD000_0000,1'b0,1'b0,32'd9);
    vecs[18] = mk(1'b0,1'b0,1'b1,32'h500,1'b0,32'h0,1'b1,32'hD000_0001,1'b0,32'h304,32'h308,32'h0,  1'b1,1'b0,32'd10);
    // PC wrap-around
    vecs[19] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,        1'b0,32'h304,32'h308,32'h0,    1'b1,1'b0,32'd10);
    vecs[20] = mk(1'b1,1'b0,1'b0,32'h0,1'b1,32'hFFFF_FFFC,1'b1,32'hE000_0000,1'b1,32'h304,32'h308,32'hE000_0000,1'b0,1'b1,32'd10);
    vecs[21] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,32'h0,32'h0,1'b1,1'b0,32'd11);
    vecs[22] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hE000_0001,1'b1,32'hFFFF_FFFC,32'h0,32'hE000_0001,1'b0,1'b0,32'd11);
    vecs[23] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0,        1'b1,32'h0,32'h4,32'h0,        1'b1,1'b0,32'd12);

    drive(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0);
    rst_i = 1'b1;
    #1;
    chk_a("rst", 1'b0, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0, 32'd0);
    chk_b("rst", 1'b0, 32'h100, 32'h104, 32'h0, 1'b1, 1'b0, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].start, vecs[i].hd, vecs[i].br, vecs[i].braddr,
            vecs[i].jmp, vecs[i].jaddr, vecs[i].ack, vecs[i].data);
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].pco,
            vecs[i].instr, vecs[i].stall, vecs[i].flush, vecs[i].cnt);
      @(negedge clk_i);
    end

    // Both units now sit in FETCH with an outstanding request; reset mid-request.
    drive(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0);
    #1;
    chk("pre_rst.b_req", {31'd0, b_req}, 32'd1);
    #1;
    start_i = 1'b0;
    rst_i   = 1'b1;
    #1;
    chk_b("midrst", 1'b0, 32'h100, 32'h104, 32'h0, 1'b1, 1'b0, 32'd0);
    chk_a("midrst", 1'b0, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    // Stale ack after reset lands in IDLE and must be ignored.
    drive(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hF000_0000);
    #1;
    chk_b("stale", 1'b0, 32'h100, 32'h104, 32'h0, 1'b1, 1'b0, 32'd0);
    @(negedge clk_i);
    drive(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0);
    #1;
    chk_b("restart_idle", 1'b0, 32'h100, 32'h104, 32'h0, 1'b1, 1'b0, 32'd0);
    @(negedge clk_i);
    // Three-cycle memory after restart: two stall cycles then the ack.
    for (int w = 0; w < 2; w++) begin
      #1;
      chk_b($sformatf("lat_wait%0d", w), 1'b1, 32'h100, 32'h104, 32'h0, 1'b1, 1'b0, 32'd0);
      chk_a($sformatf("lat_wait%0d", w), 1'b1, 32'h0, 32'h4, 32'h0, 1'b1, 1'b0, 32'd0);
      @(negedge clk_i);
    end
    drive(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,32'hF000_0001);
    #1;
    chk_b("lat_ack", 1'b1, 32'h100, 32'h104, 32'hF000_0001, 1'b0, 1'b0, 32'd0);
    chk_a("lat_ack", 1'b1, 32'h0, 32'h4, 32'hF000_0001, 1'b0, 1'b0, 32'd0);
    @(negedge clk_i);
    drive(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,32'h0);
    #1;
    chk_b("after_ack", 1'b1, 32'h104, 32'h108, 32'h0, 1'b1, 1'b0, 32'd1);
    chk_a("after_ack", 1'b1, 32'h4, 32'h8, 32'h0, 1'b1, 1'b0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
